// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Gives NREQ write-domain requesters shared use of the single write port of
// the dual-clock FIFO. Arbitration is round-robin. Once a requester is
// granted, it keeps the grant until its last beat or MAX_BURST beats,
// whichever comes first. The whole block runs in the wclk domain and drives
// the FIFO write interface directly.
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   DSIZE      data width (same as the FIFO data width)
//   MAX_BURST  maximum number of beats per grant (1..255)
//
// Ports:
//   wclk        write-domain clock
//   wrst_n      asynchronous active-low reset
//   req_valid   per-requester beat valid
//   req_last    per-requester last beat of packet (qualified by req_valid)
//   req_data    flattened data, requester i at [i*DSIZE +: DSIZE]
//   req_ready   per-requester beat accepted
//   wfull       FIFO full flag (registered inside the FIFO)
//   winc        FIFO write enable
//   wdata       FIFO write data (zero while idle)
//   grant       one-hot current owner (zero while idle)
//   busy        high while a grant is held
//
// Optional feature, enabled by defining FIFO_WR_ARB_STATS_EN:
//   stat_clr         synchronous clear of all statistics counters
//   stat_beats       per-requester accepted-beat count, 16 bits each, saturating
//   stat_full_stall  number of granted cycles with owner valid and FIFO full
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NREQ*16-1:0]    stat_beats,
    output logic [15:0]           stat_full_stall
`endif
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  rr_q, rr_d;      // last owner; in GRANT it is also the current owner
    logic [CNT_W-1:0]  cnt_q, cnt_d;    // beats accepted in the current grant

    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic              win_found;
    logic              accept;
    logic              release_burst;

    // Round-robin search: the first valid requester starting from rr+1,
    // wrapping around to rr itself last.
    always_comb begin
        cand       = '0;
        win_idx    = rr_q;
        win_onehot = '0;
        win_found  = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(rr_q) + off) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IDX_W'(NREQ - 1);   // requester 0 wins first after reset
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A beat is transferred whenever winc is high; the burst ends on the
    // owner's last beat or on the MAX_BURST-th beat (a single release if both).
    assign accept        = winc;
    assign release_burst = accept && (req_last[rr_q] || (cnt_q == LAST_CNT));

    // Next-state logic.
    // NOTE: every signal gets a default at the top of a combinational block,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = win_onehot;
                    rr_d    = win_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // Requests from non-owners are ignored here. The forced
                // return to IDLE gives the mandatory bubble cycle.
                if (release_burst) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        busy      = 1'b0;
        if (state_q == GRANT) begin
            busy      = 1'b1;
            req_ready = wfull ? '0 : grant_q;
            winc      = req_valid[rr_q] & ~wfull;
            wdata     = req_data[rr_q*DSIZE +: DSIZE];
        end
    end

    assign grant = grant_q;

`ifdef FIFO_WR_ARB_STATS_EN
    // Statistics counters. They saturate at all-ones, and a clear takes
    // priority over an increment in the same cycle.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stat_beats      <= '0;
            stat_full_stall <= '0;
        end else if (stat_clr) begin
            stat_beats      <= '0;
            stat_full_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && grant_q[i] && (stat_beats[i*16 +: 16] != 16'hFFFF)) begin
                    stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
                end
            end
            if (busy && req_valid[rr_q] && wfull && (stat_full_stall != 16'hFFFF)) begin
                stat_full_stall <= stat_full_stall + 16'd1;
            end
        end
    end
`endif

endmodule
